// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data-port responder: MMIO map, STATUS layout and bus widths.
package data_bus_responder_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LED_W      = 16;
  localparam int unsigned DROPS_W    = 16;
  localparam int unsigned TX_W       = 8;
  localparam int unsigned OFS_W      = 8;

  localparam logic [DATA_W-1:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

  localparam logic [OFS_W-1:0] OFS_LED    = 8'h00;
  localparam logic [OFS_W-1:0] OFS_TXDATA = 8'h04;
  localparam logic [OFS_W-1:0] OFS_STATUS = 8'h08;
  localparam logic [OFS_W-1:0] OFS_CYCLES = 8'h0C;
  localparam logic [OFS_W-1:0] OFS_DROPS  = 8'h10;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_ERR       = 2;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is visible combinationally from state.
// A push into a full FIFO is accepted when a pop frees an entry in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM plus an MMIO window (LED, TX FIFO, STATUS, CYCLES, DROPS).
// Read data is registered, one cycle after the request is sampled.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned       RAM_WORDS  = 256,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic [LED_W-1:0]  led_out,
  output logic [TX_W-1:0]   tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0]  ram_q [RAM_WORDS];
  logic [DATA_W-1:0]  q_q, q_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [DATA_W-1:0]  cycles_q, cycles_d;
  logic [DROPS_W-1:0] drops_q, drops_d;
  logic               err_q, err_d;

  logic               is_ram, is_mmio;
  logic [OFS_W-1:0]   ofs;
  logic [RAM_AW-1:0]  ram_idx;
  logic               ram_we;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [TX_W-1:0]    fifo_dout;
  logic [DATA_W-1:0]  status_val;
  logic               unused_addr_lsbs;

  assign is_ram           = ((address >> (RAM_AW + 2)) == 32'd0);
  assign is_mmio          = (address[31:8] == MMIO_BASE[31:8]);
  assign ofs              = {address[7:2], 2'b00};
  assign ram_idx          = address[RAM_AW+1:2];
  assign unused_addr_lsbs = ^address[1:0];

  assign fifo_pop = !fifo_empty && tx_ready;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_dout;
  assign q        = q_q;
  assign led_out  = led_q;

  sync_fifo #(
    .WIDTH (TX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data[TX_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // STATUS word assembled from live FIFO state and the sticky error flag.
  always_comb begin
    status_val                                = '0;
    status_val[ST_FULL]                       = fifo_full;
    status_val[ST_EMPTY]                      = fifo_empty;
    status_val[ST_ERR]                        = err_q;
    status_val[ST_COUNT_LSB +: ST_COUNT_W]    = ST_COUNT_W'(fifo_count);
  end

  // Request decode: read mux plus register side effects.
  always_comb begin
    q_d       = '0;
    led_d     = led_q;
    cycles_d  = cycles_q + 32'd1;
    drops_d   = drops_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    fifo_push = 1'b0;
    if (is_ram) begin
      q_d    = ram_q[ram_idx];
      ram_we = wren && !rst;
    end else if (is_mmio) begin
      case (ofs)
        OFS_LED: begin
          q_d = {{(DATA_W-LED_W){1'b0}}, led_q};
          if (wren) led_d = data[LED_W-1:0];
        end
        OFS_TXDATA: begin
          if (wren) begin
            fifo_push = !rst;
            if (fifo_full && !fifo_pop && drops_q != {DROPS_W{1'b1}})
              drops_d = drops_q + DROPS_W'(1);
          end
        end
        OFS_STATUS: begin
          q_d = status_val;
          if (wren) err_d = 1'b0;
        end
        OFS_CYCLES: begin
          q_d = cycles_q;
          if (wren) cycles_d = '0;
        end
        OFS_DROPS: begin
          q_d = {{(DATA_W-DROPS_W){1'b0}}, drops_q};
          if (wren) drops_d = '0;
        end
        default: err_d = 1'b1;
      endcase
    end else begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      led_q    <= '0;
      cycles_q <= '0;
      drops_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      led_q    <= led_d;
      cycles_q <= cycles_d;
      drops_q  <= drops_d;
      err_q    <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= data;
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder.
module tb_data_bus_responder;

  localparam logic [31:0] MB      = 32'hFFFF_FF00;
  localparam logic [31:0] A_LED   = MB + 32'h00;
  localparam logic [31:0] A_TX    = MB + 32'h04;
  localparam logic [31:0] A_STAT  = MB + 32'h08;
  localparam logic [31:0] A_CYC   = MB + 32'h0C;
  localparam logic [31:0] A_DROPS = MB + 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic [15:0] led_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  data_bus_responder dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .led_out  (led_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request per cycle; returns 1 time unit after the sampling edge.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
    address = a;
    data    = d;
    wren    = w;
    @(posedge clk);
    #1;
    address = 32'h0;
    data    = 32'h0;
    wren    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus(a, 32'h0, 1'b0);
    check_eq(tag, q, exp);
  endtask

  logic [7:0] exp_bytes [8];

  initial begin
    rst      = 1'b1;
    address  = 32'h0;
    data     = 32'h0;
    wren     = 1'b0;
    tx_ready = 1'b0;

    idle(2);
    check_eq("rst_q", q, 32'h0);
    check_eq("rst_led", 32'(led_out), 32'h0);
    check_eq("rst_txv", 32'(tx_valid), 32'h0);
    rst = 1'b0;

    idle(5);
    rd_chk("cycles_at_5", A_CYC, 32'd5);

    bus(32'h10, 32'h1234_5678, 1'b1);
    rd_chk("ram_rd_10", 32'h10, 32'h1234_5678);
    rd_chk("ram_rd_13", 32'h13, 32'h1234_5678);
    bus(32'h0, 32'h1111_2222, 1'b1);
    bus(32'h20, 32'h0BAD_0001, 1'b1);
    bus(32'h20, 32'hAAAA_5555, 1'b1);
    check_eq("ram_read_first", q, 32'h0BAD_0001);
    rd_chk("ram_rd_20", 32'h20, 32'hAAAA_5555);
    bus(32'h3FC, 32'hCAFE_F00D, 1'b1);
    rd_chk("ram_last_word", 32'h3FC, 32'hCAFE_F00D);

    bus(A_LED, 32'hFFFF_ABCD, 1'b1);
    check_eq("led_out", 32'(led_out), 32'h0000_ABCD);
    rd_chk("led_rd", A_LED, 32'h0000_ABCD);

    rd_chk("stat_empty", A_STAT, 32'h0000_0002);
    for (int i = 0; i < 9; i++) bus(A_TX, 32'(8'h41 + i), 1'b1);
    rd_chk("stat_full", A_STAT, 32'h0000_0801);
    rd_chk("drops_1", A_DROPS, 32'd1);
    rd_chk("txdata_rd0", A_TX, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("ovf_txv", 32'(tx_valid), 32'h1);
      check_eq("ovf_txd", 32'(tx_data), 32'(8'h41 + i));
      idle(1);
    end
    check_eq("ovf_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    for (int i = 0; i < 8; i++) bus(A_TX, 32'(8'h50 + i), 1'b1);
    tx_ready = 1'b1;
    bus(A_TX, 32'h5A, 1'b1);
    tx_ready = 1'b0;
    rd_chk("fullpop_stat", A_STAT, 32'h0000_0801);
    rd_chk("fullpop_drops", A_DROPS, 32'd1);
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'(8'h51 + i);
    exp_bytes[7] = 8'h5A;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("fullpop_txv", 32'(tx_valid), 32'h1);
      check_eq("fullpop_txd", 32'(tx_data), 32'(exp_bytes[i]));
      idle(1);
    end
    check_eq("fullpop_drained", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    bus(A_CYC, 32'h1234, 1'b1);
    idle(3);
    rd_chk("cycles_after_clr", A_CYC, 32'd3);

    bus(A_DROPS, 32'h0, 1'b1);
    rd_chk("drops_clr", A_DROPS, 32'd0);
    for (int i = 0; i < 8; i++) bus(A_TX, 32'(8'h60 + i), 1'b1);
    repeat (65534) bus(A_TX, 32'h77, 1'b1);
    rd_chk("drops_fffe", A_DROPS, 32'h0000_FFFE);
    repeat (2) bus(A_TX, 32'h77, 1'b1);
    rd_chk("drops_sat", A_DROPS, 32'h0000_FFFF);
    bus(A_TX, 32'h77, 1'b1);
    rd_chk("drops_hold", A_DROPS, 32'h0000_FFFF);
    rd_chk("stat_full2", A_STAT, 32'h0000_0801);

    rd_chk("unmapped_rd", 32'h8000_0000, 32'h0);
    rd_chk("stat_err", A_STAT, 32'h0000_0805);
    bus(A_STAT, 32'h0, 1'b1);
    check_eq("stat_wr_rd_old", q, 32'h0000_0805);
    rd_chk("stat_err_clr", A_STAT, 32'h0000_0801);
    bus(32'h400, 32'hDEAD_BEEF, 1'b1);
    check_eq("unmapped_wr_q", q, 32'h0);
    rd_chk("ram_no_alias", 32'h0, 32'h1111_2222);
    rd_chk("stat_err2", A_STAT, 32'h0000_0805);
    bus(A_STAT, 32'h0, 1'b1);
    bus(MB + 32'h14, 32'h1, 1'b1);
    check_eq("mmio_hole_q", q, 32'h0);
    rd_chk("led_unchanged", A_LED, 32'h0000_ABCD);
    rd_chk("stat_err3", A_STAT, 32'h0000_0805);

    tx_ready = 1'b1;
    idle(8);
    tx_ready = 1'b0;
    check_eq("pre_rst_empty", 32'(tx_valid), 32'h0);
    for (int i = 0; i < 3; i++) bus(A_TX, 32'(8'h31 + i), 1'b1);
    check_eq("pre_rst_txv", 32'(tx_valid), 32'h1);
    check_eq("pre_rst_txd", 32'(tx_data), 32'h31);
    rst = 1'b1;
    bus(A_LED, 32'h5555, 1'b1);
    check_eq("rst2_txv", 32'(tx_valid), 32'h0);
    check_eq("rst2_q", q, 32'h0);
    check_eq("rst2_led", 32'(led_out), 32'h0);
    rst = 1'b0;
    rd_chk("rst2_cycles0", A_CYC, 32'd0);
    rd_chk("rst2_stat", A_STAT, 32'h0000_0002);
    rd_chk("rst2_drops", A_DROPS, 32'd0);
    rd_chk("rst2_ram", 32'h10, 32'h1234_5678);
    rd_chk("rst2_led_rd", A_LED, 32'h0);
    check_eq("rst2_txv_hold", 32'(tx_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder at the far end of the processor's data-memory port. The processor's MEMWB stage drives address, data and wren.
- Serves word reads and writes to an internal data RAM and a small MMIO region:
  - LED register
  - byte transmit FIFO with a valid/ready output
  - status register
  - free-running cycle counter
  - dropped-byte counter
- Replaces the bare RAM on the data port. Returns read data with the same one-cycle registered latency.

Parameters:
- RAM_WORDS, 256, number of 32-bit data RAM words; power of two.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2, at most 15.
- MMIO_BASE, 32'hFFFF_FF00, base byte address of the MMIO window; 256-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- address  input  32  byte address of the request; bits [1:0] ignored.
- data  input  32  write data.
- wren  input  1  1 = write request this cycle, 0 = read request.
- q  output  32  read data, registered.
- led_out  output  16  LED register contents.
- tx_data  output  8  byte at the FIFO head.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts the head byte this cycle.

Behaviour:
- A request is presented every cycle; there is no request-valid signal.
- Address decode:
  - RAM: address < RAM_WORDS*4. Word index is address[log2(RAM_WORDS)+1:2].
  - MMIO: address[31:8] == MMIO_BASE[31:8]. Offset is address[7:0].
  - Any other address is unmapped.
- MMIO map, by offset:
  - 0x00 LED: read/write; bits [15:0] used; reads zero-extend.
  - 0x04 TXDATA: a write pushes data[7:0]; reads return 0.
  - 0x08 STATUS: read only, except bit2.
    - bit0 = full, bit1 = empty, bit2 = sticky unmapped-access error.
    - bits [11:8] = FIFO count.
    - Any write to STATUS clears bit2.
  - 0x0C CYCLES: 32-bit counter; increments every non-reset cycle and wraps at 2^32. A write sets it to 0.
  - 0x10 DROPS: 16-bit saturating count of rejected pushes; any write clears it.
  - Any other offset in the window is unmapped.
- Reads:
  - q takes the addressed value at the posedge that samples the request. It is valid the whole next cycle.
  - A register read returns its value before that edge's update.
  - RAM read and write to the same word in one cycle is read-first: q shows the old word.
- Unmapped access, read or write:
  - q = 0 and status bit2 is set.
  - Writes have no effect.
- Writes: RAM, LED and counters update at the sampling edge. led_out reflects a LED write from the next cycle.
- TX FIFO:
  - tx_data is the head entry and tx_valid = !empty, both combinational from state.
  - A pop occurs when tx_valid && tx_ready.
  - Push only: accepted if not full, else dropped and DROPS increments, saturating at 16'hFFFF.
  - Push and pop in the same cycle while full: the push is accepted and the count stays FIFO_DEPTH.
  - Push while empty: no fall-through; tx_valid rises the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count never exceeds FIFO_DEPTH.
- Reset, synchronous and taking priority over any request that cycle:
  - q = 0, led_out = 0, FIFO emptied (tx_valid = 0), CYCLES = 0, DROPS = 0, error bit = 0.
  - RAM contents are not cleared.
  - A reset mid-stream discards queued bytes.
  - CYCLES reads 0 in the first cycle after rst deasserts.
- tx_data is don't-care while tx_valid = 0; the bench must not check it then.

Decomposition:
- Shared package holds:
  - the MMIO offset constants (OFS_LED, OFS_TXDATA, OFS_STATUS, OFS_CYCLES, OFS_DROPS)
  - the MMIO_BASE default
  - the STATUS bit positions (ST_FULL, ST_EMPTY, ST_ERR, ST_COUNT_LSB)
- One sub-module: sync_fifo (parameters WIDTH and DEPTH).
  - Inputs: push, pop, din. Outputs: dout, full, empty, count.
  - Push is accepted when full if pop is asserted the same cycle.
- Address decode, the register file and the RAM array stay in data_bus_responder.

Test Plan:
- RAM: write 0x12345678 to 0x10, then read 0x10 and 0x13 → q = 0x12345678 one cycle after each read. Same-cycle read and write of word 0x20 with 0xAAAA5555 → q shows the prior value; the next read shows 0xAAAA5555.
- LED: write 0xFFFFABCD to MMIO_BASE+0x00 → led_out = 0xABCD from the next cycle; a read returns 0x0000ABCD.
- FIFO overflow: with tx_ready = 0, push 0x41..0x49 (9 bytes) → STATUS = full 1, count 8; DROPS = 1. Then tx_ready = 1 → bytes 0x41..0x48 emitted in order, one per cycle, then tx_valid = 0.
- Full push with simultaneous pop: fill to 8, set tx_ready = 1 and push 0x5A → count stays 8, DROPS unchanged, 0x5A is emitted last.
- Counters: deassert rst, read CYCLES at cycle 5 → 5. Write CYCLES → a later read counts from 0. Force 0x10000 rejected pushes → DROPS holds at 0xFFFF.
- Unmapped read of 0x80000000 → q = 0 and STATUS bit2 = 1; a write to STATUS clears it. Assert rst with 3 bytes queued → tx_valid = 0 next cycle, and a previously written RAM word still reads back unchanged.
